fwrisc_muldiv: RTL and testbench

Iterative, area-minimal RV32M multiply/divide unit for the fwrisc core. It contains no adder of its own: every add, subtract and compare is issued to an external instance of the shared combinational `fwrisc_alu` through a dedicated operand/op port, and the unit consumes the ALU's `out` in the same cycle. The unit accepts one request at a time from the execute stage and returns one 32-bit result through a valid/ready handshake.

---
 rtl/fwrisc_alu_pkg.sv | 11 +
 rtl/fwrisc_muldiv_pkg.sv | 10 +
 rtl/fwrisc_alu.sv | 18 +
 rtl/fwrisc_muldiv.sv | 123 ++++++++++++
 tb/tb_fwrisc_muldiv.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fwrisc_alu_pkg.sv
// fwrisc_alu_pkg: shared ALU operation codes used by fwrisc_alu and its clients
package fwrisc_alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LT  = 4'd5;
  localparam logic [3:0] OP_LTU = 4'd6;
  localparam logic [3:0] OP_NOP = 4'd15;
endpackage

// File: rtl/fwrisc_muldiv_pkg.sv
// fwrisc_muldiv_pkg: funct3 encodings, FSM states and iteration-count width
package fwrisc_muldiv_pkg;
  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam int CNT_W = 6;
  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, MUL_STEP, DIV_CMP, DIV_SUB, FIX, DONE} state_t;
endpackage

// File: rtl/fwrisc_alu.sv
// fwrisc_alu: shared combinational ALU; OP_NOP passes operand A through
module fwrisc_alu
  import fwrisc_alu_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [3:0]  op,
  output logic [31:0] out
);
  always_comb
    out = op == OP_ADD ? op_a + op_b :
          op == OP_SUB ? op_a - op_b :
          op == OP_AND ? op_a & op_b :
          op == OP_OR  ? op_a | op_b :
          op == OP_XOR ? op_a ^ op_b :
          op == OP_LT  ? {31'b0, $signed(op_a) < $signed(op_b)} :
          op == OP_LTU ? {31'b0, op_a < op_b} : op_a;
endmodule

// File: rtl/fwrisc_muldiv.sv
// fwrisc_muldiv: iterative RV32M mul/div that borrows the shared ALU for every add, subtract and compare
module fwrisc_muldiv
  import fwrisc_alu_pkg::*;
  import fwrisc_muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out
);
  state_t state, state_n;
  logic [2:0] op;
  logic [31:0] x, y, r;
  logic [CNT_W-1:0] cnt;
  logic b_zero, a_neg, b_neg, rem_hi, lt;
  logic last, sel_quo, fix_neg, take;
  logic [31:0] result;
  assign last = cnt == CNT_W'(31);
  assign sel_quo = ~op[1];
  assign fix_neg = sel_quo ? (a_neg ^ b_neg) & ~b_zero : a_neg;
  assign take = rem_hi | ~lt;
  assign result = (op == F3_MUL || op[2:1] == 2'b11) ? r : op[2:1] == 2'b10 ? x : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !req_valid ? IDLE :
                          req_op == F3_MUL ? MUL_STEP :
                          (req_op == F3_DIVU || req_op == F3_REMU) ? DIV_CMP :
                          (req_op == F3_DIV || req_op == F3_REM) ? NEG_A : DONE;
      NEG_A:    state_n = NEG_B;
      NEG_B:    state_n = DIV_CMP;
      MUL_STEP: state_n = last ? DONE : MUL_STEP;
      DIV_CMP:  state_n = DIV_SUB;
      DIV_SUB:  state_n = !last ? DIV_CMP : op[0] ? DONE : FIX;
      FIX:      state_n = DONE;
      DONE:     state_n = (rsp_valid && rsp_ready) ? IDLE : DONE;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    alu_op = OP_NOP;
    alu_op_a = '0;
    alu_op_b = '0;
    case (state)
      NEG_A:    begin alu_op = a_neg ? OP_SUB : OP_NOP; alu_op_b = x; end
      NEG_B:    begin alu_op = b_neg ? OP_SUB : OP_NOP; alu_op_b = y; end
      MUL_STEP: begin alu_op = y[0] ? OP_ADD : OP_NOP; alu_op_a = r; alu_op_b = x; end
      DIV_CMP:  begin alu_op = OP_LTU; alu_op_a = {r[30:0], x[31]}; alu_op_b = y; end
      DIV_SUB:  begin alu_op = OP_SUB; alu_op_a = r; alu_op_b = y; end
      FIX:      begin alu_op = fix_neg ? OP_SUB : OP_NOP; alu_op_b = sel_quo ? x : r; end
      default:  ;
    endcase
  end
  // x: multiplicand / dividend-then-quotient, y: multiplier / divisor, r: accumulator / remainder
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      op <= '0;
      x <= '0;
      y <= '0;
      r <= '0;
      cnt <= '0;
      b_zero <= 1'b0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      rem_hi <= 1'b0;
      lt <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= state == DONE && !(rsp_valid && rsp_ready);
      if (state == DONE && !rsp_valid) rsp_data <= result;
      case (state)
        IDLE: if (req_valid) begin
          op <= req_op;
          x <= req_a;
          y <= req_b;
          r <= '0;
          cnt <= '0;
          b_zero <= req_b == '0;
          a_neg <= req_a[31];
          b_neg <= req_b[31];
        end
        NEG_A: if (a_neg) x <= alu_out;
        NEG_B: if (b_neg) y <= alu_out;
        MUL_STEP: begin
          r <= alu_out;
          x <= x << 1;
          y <= y >> 1;
          cnt <= cnt + 1'b1;
        end
        DIV_CMP: begin
          r <= {r[30:0], x[31]};
          rem_hi <= r[31];
          lt <= alu_out[0];
          x <= x << 1;
        end
        DIV_SUB: begin
          if (take) r <= alu_out;
          x[0] <= take;
          cnt <= cnt + 1'b1;
        end
        FIX: if (fix_neg) begin
          if (sel_quo) x <= alu_out;
          else r <= alu_out;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fwrisc_muldiv.sv
// tb_fwrisc_muldiv: directed and randomized checks of fwrisc_muldiv against an arithmetic RV32M model
module tb_fwrisc_muldiv;
  import fwrisc_alu_pkg::*;
  import fwrisc_muldiv_pkg::*;
  logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0] req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic req_ready, rsp_valid;
  logic [31:0] rsp_data, alu_op_a, alu_op_b, alu_out;
  logic [3:0] alu_op;
  int checks = 0, failures = 0;
  fwrisc_muldiv dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .alu_op_a(alu_op_a),
    .alu_op_b(alu_op_b), .alu_op(alu_op), .alu_out(alu_out)
  );
  fwrisc_alu u_alu (.op_a(alu_op_a), .op_b(alu_op_b), .op(alu_op), .out(alu_out));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sr;
    logic ovf;
    sa = a;
    sb = b;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      F3_MUL:  return a * b;
      F3_DIVU: return b == 0 ? 32'hFFFF_FFFF : a / b;
      F3_REMU: return b == 0 ? a : a % b;
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        sr = sa / sb;
        return sr;
      end
      F3_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sr = sa % sb;
        return sr;
      end
      default: return 32'h0;
    endcase
  endfunction
  function automatic int lat_of(input logic [2:0] op);
    case (op)
      F3_MUL: return 33;
      F3_DIVU, F3_REMU: return 65;
      F3_DIV, F3_REM: return 68;
      default: return 1;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int hold);
    int lat;
    logic [31:0] d0;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    chk("alu_op_idle", 32'(alu_op), 32'(OP_NOP));
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk($sformatf("latency op=%0d", op), 32'(lat), 32'(lat_of(op)));
    chk($sformatf("rsp_data op=%0d a=%h b=%h", op, a, b), rsp_data, exp);
    d0 = rsp_data;
    repeat (hold) begin
      @(posedge clock);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, d0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    int seen;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'(OP_NOP));
    chk("rst_alu_a", alu_op_a, 32'd0);
    chk("rst_alu_b", alu_op_b, 32'd0);
    chk("rst_cnt", 32'(dut.cnt), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    run(F3_MUL, 32'd7, 32'd6, 32'd42, 0);
    run(F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0);
    run(F3_DIVU, 32'd100, 32'd7, 32'd14, 0);
    run(F3_REMU, 32'd100, 32'd7, 32'd2, 0);
    run(F3_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 0);
    run(F3_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 0);
    run(F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run(F3_REMU, 32'd5, 32'd0, 32'd5, 0);
    run(F3_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF, 0);
    run(F3_REM, -32'sd5, 32'd0, 32'hFFFF_FFFB, 0);
    run(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    run(F3_DIVU, 32'd1000, 32'd33, 32'd30, 10);
    run(3'b001, 32'd9, 32'd9, 32'd0, 0);
    req_valid = 1'b1;
    req_op = F3_DIVU;
    req_a = 32'd12345;
    req_b = 32'd7;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_alu_op", 32'(alu_op), 32'(OP_NOP));
    @(posedge clock);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clock);
      #1;
      seen += int'(rsp_valid);
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    run(F3_MUL, 32'd3, 32'd5, 32'd15, 0);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run(op, a, b, model(op, a, b), $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
